// File: rtl/keypad_scanner.sv
`default_nettype none
// keypad_scanner: strobes a 4x4 active-low keypad, debounces whole scans and
// shifts accepted keys into a 4-digit entry register.  Rev 1.0
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------
  logic [3:0] sync_q;
  logic [3:0] rs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 4'b1111;
      rs_q   <= 4'b1111;
    end else begin
      sync_q <= row;
      rs_q   <= sync_q;
    end
  end

  // ---------------------------------------------------------------
  // Column scan and snapshot capture
  // ---------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [1:0]       slot_q;
  logic [1:0]       slot_d;
  logic [3:0]       col_q;
  logic [11:0]      snap_q;
  logic             slot_end;
  logic             scan_done;

  assign div_d     = div_q + 1'b1;
  assign slot_d    = slot_q + 1'b1;
  assign slot_end  = (div_q == DIV_LAST);
  assign scan_done = slot_end && (slot_q == 2'd3);

  // Slot 3 is never stored: its sample is taken straight from rs_q on the
  // completion cycle, so only columns 0..2 need snapshot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      slot_q <= 2'd0;
      col_q  <= 4'b1110;
      snap_q <= '1;
    end else if (slot_end) begin
      div_q  <= '0;
      slot_q <= slot_d;
      col_q  <= {col_q[2:0], col_q[3]};
      case (slot_q)
        2'd0:    snap_q[3:0]  <= rs_q;
        2'd1:    snap_q[7:4]  <= rs_q;
        2'd2:    snap_q[11:8] <= rs_q;
        default: snap_q       <= snap_q;
      endcase
    end else begin
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------
  // Scan classification: snapshot bit 4c+r is low when key (r,c) is down
  // ---------------------------------------------------------------
  logic [15:0] snap_full;
  logic [4:0]  zero_cnt;
  logic [3:0]  cls_code;
  logic        cls_none;
  logic        cls_single;

  assign snap_full = {rs_q, snap_q};

  always_comb begin
    zero_cnt = '0;
    cls_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_full[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        cls_code = {i[1:0], i[3:2]};
      end
    end
  end

  assign cls_none   = (zero_cnt == 5'd0);
  assign cls_single = (zero_cnt == 5'd1);

  // ---------------------------------------------------------------
  // Debounce FSM with registered outputs
  // ---------------------------------------------------------------
  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic [15:0]      digits_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digits_q    <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          S_IDLE: begin
            if (cls_single) begin
              cand_q <= cls_code;
              if (DEBOUNCE_SCANS == 1) begin
                key_valid_q <= 1'b1;
                key_code_q  <= cls_code;
                digits_q    <= {digits_q[11:0], cls_code};
                key_held_q  <= 1'b1;
                cnt_q       <= CNT_MAX;
                state_q     <= S_HELD;
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= S_PRESS_DB;
              end
            end
          end

          S_PRESS_DB: begin
            if (cls_single && (cls_code == cand_q)) begin
              if (cnt_d == CNT_MAX) begin
                key_valid_q <= 1'b1;
                key_code_q  <= cand_q;
                digits_q    <= {digits_q[11:0], cand_q};
                key_held_q  <= 1'b1;
                cnt_q       <= CNT_MAX;
                state_q     <= S_HELD;
              end else begin
                cnt_q <= cnt_d;
              end
            end else if (cls_single) begin
              cand_q <= cls_code;
              cnt_q  <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end

          // Any key activity keeps the press latched; only clean releases count.
          S_HELD: begin
            if (cls_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_held_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= S_IDLE;
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= S_REL_DB;
              end
            end
          end

          S_REL_DB: begin
            if (cls_none) begin
              if (cnt_d == CNT_MAX) begin
                key_held_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= S_IDLE;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              state_q <= S_HELD;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign digits    = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// tb_keypad_scanner: scenario tasks plus randomized key sequences checked
// against a scan-level run-length model of the debounce rules.  Rev 1.0
module tb_keypad_scanner;

  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] pressed = 16'h0000;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int obs_pulses, first_pulse_cyc, col_errs, valid_errs, held_errs;

  logic        m_held, m_pulse;
  int          m_run, m_nrun, m_pulses;
  logic [3:0]  m_k, m_code;
  logic [15:0] m_digits;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .digits(digits)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_held = 1'b0; m_pulse = 1'b0; m_run = 0; m_nrun = 0; m_pulses = 0;
    m_k = 4'h0; m_code = 4'h0; m_digits = 16'h0000;
    obs_pulses = 0; first_pulse_cyc = -1; col_errs = 0; valid_errs = 0; held_errs = 0;
  endtask

  // Rule-level model: a press needs DB consecutive single-key scans of the
  // same key while released; a release needs DB consecutive empty scans.
  task automatic model_scan(input logic [15:0] m);
    int n;
    logic [3:0] k;
    n = $countones(m);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) k = 4'(i);
    if (!m_held) begin
      m_nrun = 0;
      if (n == 1) begin
        m_run = (m_run > 0 && k == m_k) ? m_run + 1 : 1;
        m_k = k;
        if (m_run >= DB) begin
          m_pulse = 1'b1; m_held = 1'b1; m_code = k;
          m_digits = {m_digits[11:0], k}; m_pulses++; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_nrun++;
      if (m_nrun >= DB) begin m_held = 1'b0; m_nrun = 0; m_run = 0; end
    end else begin
      m_nrun = 0;
    end
  endtask

  task automatic reset_dut(input logic [15:0] m);
    @(negedge clk);
    pressed = m;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  // Drives one full scan (16 cycles) with a stable key set, tallying observations.
  task automatic run_scan(input logic [15:0] m);
    logic [3:0] exp_col;
    logic       exp_v;
    for (int o = 0; o < 16; o++) begin
      pressed = m;
      exp_col = 4'b1111 ^ (4'b0001 << (o / 4));
      exp_v   = (o == 0) ? m_pulse : 1'b0;
      if (col !== exp_col) col_errs++;
      if (key_valid !== exp_v) valid_errs++;
      if (key_held !== m_held) held_errs++;
      if (key_valid === 1'b1) begin
        obs_pulses++;
        if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
      end
      if (o == 0) m_pulse = 1'b0;
      if (o == 15) model_scan(m);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_dut(16'h0000);
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h expected 0", key_code); end
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits: got %h expected 0000", digits); end
  endtask

  task automatic test_idle_scan();
    reset_dut(16'h0000);
    repeat (4) run_scan(16'h0000);
    checks++; if (col_errs !== 0) begin failures++; $display("FAIL idle_col: got %0d bad cycles expected 0", col_errs); end
    checks++; if (obs_pulses !== 0) begin failures++; $display("FAIL idle_pulses: got %0d expected 0", obs_pulses); end
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL idle_digits: got %h expected 0000", digits); end
  endtask

  task automatic test_single_key();
    reset_dut(16'h0040);
    repeat (3) run_scan(16'h0040);
    repeat (5) run_scan(16'h0000);
    checks++; if (first_pulse_cyc !== 48) begin failures++; $display("FAIL single_pulse_cycle: got %0d expected 48", first_pulse_cyc); end
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL single_pulse_count: got %0d expected 1", obs_pulses); end
    checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL single_code: got %h expected 6", key_code); end
    checks++; if (digits !== 16'h0006) begin failures++; $display("FAIL single_digits: got %h expected 0006", digits); end
    checks++; if (held_errs !== 0) begin failures++; $display("FAIL single_held_track: got %0d bad cycles expected 0", held_errs); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL single_released: got %b expected 0", key_held); end
    checks++; if (col_errs !== 0) begin failures++; $display("FAIL single_col: got %0d bad cycles expected 0", col_errs); end
  endtask

  task automatic test_sequence();
    logic [3:0] keys [5];
    keys[0] = 4'h6; keys[1] = 4'hF; keys[2] = 4'h1; keys[3] = 4'hA; keys[4] = 4'h3;
    reset_dut(16'h0000);
    for (int i = 0; i < 5; i++) begin
      repeat (6) run_scan(16'h0001 << keys[i]);
      repeat (6) run_scan(16'h0000);
    end
    checks++; if (obs_pulses !== 5) begin failures++; $display("FAIL seq_pulses: got %0d expected 5", obs_pulses); end
    checks++; if (digits !== 16'hF1A3) begin failures++; $display("FAIL seq_digits: got %h expected F1A3", digits); end
    checks++; if (key_code !== 4'h3) begin failures++; $display("FAIL seq_code: got %h expected 3", key_code); end
    checks++; if (valid_errs !== 0) begin failures++; $display("FAIL seq_valid_timing: got %0d bad cycles expected 0", valid_errs); end
    checks++; if (held_errs !== 0) begin failures++; $display("FAIL seq_held_track: got %0d bad cycles expected 0", held_errs); end
  endtask

  task automatic test_bounce();
    reset_dut(16'h0000);
    run_scan(16'h0040); run_scan(16'h0040); run_scan(16'h0000);
    run_scan(16'h0040); run_scan(16'h0040); run_scan(16'h0040);
    run_scan(16'h0040); run_scan(16'h0040);
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL bounce_pulses: got %0d expected 1", obs_pulses); end
    checks++; if (first_pulse_cyc !== 96) begin failures++; $display("FAIL bounce_pulse_cycle: got %0d expected 96", first_pulse_cyc); end
    checks++; if (valid_errs !== 0) begin failures++; $display("FAIL bounce_valid_timing: got %0d bad cycles expected 0", valid_errs); end
  endtask

  task automatic test_multi();
    reset_dut(16'h0000);
    repeat (10) run_scan(16'h0240);
    checks++; if (obs_pulses !== 0) begin failures++; $display("FAIL multi_no_pulse: got %0d expected 0", obs_pulses); end
    repeat (4) run_scan(16'h0040);
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL multi_then_single: got %0d expected 1", obs_pulses); end
    checks++; if (first_pulse_cyc !== 208) begin failures++; $display("FAIL multi_pulse_cycle: got %0d expected 208", first_pulse_cyc); end
    checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL multi_code: got %h expected 6", key_code); end
  endtask

  task automatic test_held_switch_reset();
    reset_dut(16'h0000);
    repeat (4) run_scan(16'h0040);
    repeat (4) run_scan(16'h0020);
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL switch_no_repulse: got %0d expected 1", obs_pulses); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL switch_held: got %b expected 1", key_held); end
    checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL switch_code: got %h expected 6", key_code); end
    repeat (4) run_scan(16'h0000);
    run_scan(16'h0008);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL midrst_col: got %b expected 1110", col); end
    checks++; if ({key_valid, key_held, key_code, digits} !== 22'h0) begin failures++; $display("FAIL midrst_outputs: got %h expected 0", {key_valid, key_held, key_code, digits}); end
    rst = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) run_scan(16'h0008);
    checks++; if (obs_pulses !== 0) begin failures++; $display("FAIL midrst_counter_cleared: got %0d expected 0", obs_pulses); end
    run_scan(16'h0008);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL midrst_accept: got %b expected 1", key_valid); end
    checks++; if (key_code !== 4'h3) begin failures++; $display("FAIL midrst_code: got %h expected 3", key_code); end
  endtask

  task automatic test_random();
    int kind, len, k1, k2;
    logic [15:0] m;
    reset_dut(16'h0000);
    repeat (40) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       m = 16'h0000;
        3:       m = (16'h0001 << k1) | (16'h0001 << k2);
        default: m = 16'h0001 << k1;
      endcase
      repeat (len) run_scan(m);
    end
    run_scan(16'h0000);
    checks++; if (valid_errs !== 0) begin failures++; $display("FAIL rand_valid_timing: got %0d bad cycles expected 0", valid_errs); end
    checks++; if (held_errs !== 0) begin failures++; $display("FAIL rand_held_track: got %0d bad cycles expected 0", held_errs); end
    checks++; if (obs_pulses !== m_pulses) begin failures++; $display("FAIL rand_pulses: got %0d expected %0d", obs_pulses, m_pulses); end
    checks++; if (digits !== m_digits) begin failures++; $display("FAIL rand_digits: got %h expected %h", digits, m_digits); end
    checks++; if (key_code !== m_code) begin failures++; $display("FAIL rand_code: got %h expected %h", key_code, m_code); end
    checks++; if (col_errs !== 0) begin failures++; $display("FAIL rand_col: got %0d bad cycles expected 0", col_errs); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_single_key();
    test_sequence();
    test_bounce();
    test_multi();
    test_held_switch_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by strobing its columns active-low, reads the rows, and debounces the result.
- Reports each new keypress as a 4-bit code with a one-cycle valid pulse.
- Shifts every accepted key into a 4-digit entry register whose 16-bit output feeds the 7-segment display multiplexer's q input.
- Sits at the board I/O edge; it is the input-side counterpart to the display scan logic.

Parameters:
- SCAN_DIV, 4, clocks per column slot (minimum 4).
- DEBOUNCE_SCANS, 3, consecutive identical full scans required to accept a press or a release (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- row  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- col  out  4  column strobes, active-low one-hot, registered.
- key_code  out  4  code of the last accepted key, code = 4*r + c.
- key_valid  out  1  one-cycle pulse on an accepted press.
- key_held  out  1  high from the accept cycle until the release is accepted.
- digits  out  16  entry register; the newest key is in [3:0] and older keys shift toward [15:12].

Behaviour:
- Reset (synchronous, any cycle, including mid-scan or mid-debounce):
  - col=4'b1110, slot index=0, divider=0.
  - Snapshot and debounce counter cleared; FSM=IDLE.
  - key_code=0, key_valid=0, key_held=0, digits=0.
  - Synchronizer flops = 4'b1111.
- Synchronization: row passes through a 2-flop synchronizer. All logic uses the synchronized value rs.
- Scan:
  - Divider counts 0..SCAN_DIV-1. Slot c has col[c]=0 and all other columns 1.
  - On the divider's terminal cycle, rs is sampled into snapshot bits [4c+3:4c]. Then col advances with wrap 3->0 and the divider returns to 0.
  - Slot 3's terminal cycle completes a full scan (4*SCAN_DIV cycles). Scans repeat back-to-back.
- Classification at scan completion, using the snapshot including the slot-3 sample taken that cycle:
  - NONE: all bits 1.
  - SINGLE(code): exactly one bit 0, at row r, column c, with code = 4*r + c.
  - MULTI: two or more bits 0.
- FSM, evaluated only on scan-completion cycles. The counter cnt saturates at DEBOUNCE_SCANS.
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI: stay.
  - PRESS_DB:
    - SINGLE(cand): cnt+1; when cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other k): cand=k, cnt=1.
    - NONE or MULTI: cnt=0, go to IDLE.
  - Accept (registered, all effective the next cycle):
    - key_valid=1 for exactly that cycle; key_code=cand.
    - digits={digits[11:0],cand}; key_held=1.
    - Go to HELD.
  - HELD:
    - NONE: cnt=1, go to REL_DB. If DEBOUNCE_SCANS=1, release immediately instead.
    - SINGLE (any code) or MULTI: stay. A key change without a release never produces a new pulse.
  - REL_DB:
    - NONE: cnt+1; when cnt reaches DEBOUNCE_SCANS, release.
    - Anything else: go back to HELD.
  - Release: key_held=0, go to IDLE. key_code keeps its last value.
- Pulse rules: key_valid is never high on two consecutive cycles. At most one pulse per press/release cycle.
- Worst-case accept latency from a stable press: (DEBOUNCE_SCANS+1) full scans plus 3 cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; cycle 0 = first cycle after rst falls; the bench keypad model drives row[r]=0 whenever col[c]=0 for each pressed key):
- Idle scan, no keys -> col follows 1110,1101,1011,0111 with 4 cycles each, repeating every 16 cycles; key_valid never asserts; digits=0.
- Key r=1,c=2 held from cycle 0 -> key_valid=1 only in cycle 48; key_code=6; digits=16'h0006; key_held=1 until the release is accepted.
- Keys 6, then 0xF, then 0x1, then 0xA, then 0x3, each pressed for 6 scans and released for 6 scans -> five pulses; final digits=16'hF1A3.
- Bounce: key 6 present in 2 scans, absent in 1, present in 3 -> exactly one pulse, at the end of the 3rd contiguous scan after the gap.
- Keys 6 and 9 pressed together for 10 scans -> no pulse. Then 9 is released with 6 still held -> pulse with code 6 after 3 scans.
- While HELD on key 6, switch to key 5 without a 3-scan release -> no second pulse. rst asserted mid-debounce -> next cycle col=1110, all outputs 0, FSM IDLE.
